board_input_debounce: RTL
=========================

# board_input_debounce

Synchronises and debounces the Nexys3 slide switches and push buttons before they reach the board I/O register block. Each input passes through a two-flop synchroniser and then a per-input stable-sample filter clocked by a shared prescaled tick. The block presents a clean level vector, with optional one-cycle rise/fall strobes. Bit order matches the board input register, so the downstream wishbone block and its change interrupt see glitch-free values.

## Interface
- `CLK_FREQ`, default 100: clock frequency in MHz.
- `SAMPLE_US`, default 1000: sample tick period in µs; `TICK_DIV = CLK_FREQ*SAMPLE_US` cycles, which must be ≥ 2.
- `STABLE_CNT`, default 8: consecutive disagreeing samples required to accept a new level; must be ≥ 1.
- `clk`  in  1: main clock. One clock domain only.
- `rst`  in  1: reset, synchronous and active-high.
- `switch`  in  8: raw slide switches, asynchronous.
- `btn_l`, `btn_r`, `btn_u`, `btn_d`, `btn_s`  in  1 each: raw buttons, asynchronous, active-high.
- `in_db`  out  13: debounced levels, ordered {btn_s, btn_l, btn_r, btn_u, btn_d, switch[7:0]} (switch bits 0–7, btn_d 8, btn_u 9, btn_r 10, btn_l 11, btn_s 12).
- `in_rise`  out  13: one-cycle strobe when an `in_db` bit goes 0→1.
- `in_fall`  out  13: one-cycle strobe when an `in_db` bit goes 1→0.
- `in_changed`  out  1: one-cycle strobe, equal to the OR of all `in_rise` and `in_fall` bits.

## Operation
- **Raw vector:** the raw 13-bit vector is assembled in the `in_db` bit order.
- **Synchroniser:** two flops, `sync1 <= raw`, `sync2 <= sync1`. Only `sync2` feeds the filter.
- **Prescaler:** `pre` counts 0..TICK_DIV-1 and wraps to 0. `tick = (pre == TICK_DIV-1)`. Width is `clog2(TICK_DIV)`.
- **Filter state:** one counter per bit, `cnt[i]`, width `clog2(STABLE_CNT+1)`.
- **Filter update:** happens only on `tick`; between ticks `cnt` and `in_db` hold.
  - `sync2[i] == in_db[i]`: `cnt[i] <= 0`.
  - `sync2[i] != in_db[i]` and `cnt[i] == STABLE_CNT-1`: `in_db[i] <= sync2[i]` and `cnt[i] <= 0`.
  - `sync2[i] != in_db[i]` otherwise: `cnt[i] <= cnt[i]+1`.
- **Glitch rejection:** a sample that agrees with `in_db` restarts the count, so pulses shorter than `STABLE_CNT` consecutive ticks are rejected. Any edge that falls between two ticks is invisible.
- **Strobes:** registered on the same edge as the `in_db` update.
  - `in_rise[i] <= accept[i] & sync2[i]`
  - `in_fall[i] <= accept[i] & ~sync2[i]`
  - `in_changed <= |accept`
  - All three are 0 in every cycle without an accept.
- **Simultaneous accepts:** several bits may accept on the same tick. All of their strobes assert together and `in_changed` pulses once.
- **Width rule:** `cnt` never exceeds `STABLE_CNT-1`.

## Timing
- **Reset values:** all outputs 0, and `sync1`, `sync2`, `pre` and `cnt` are all 0. After reset, `pre` = 0 on the first cycle.
- **Inputs high at reset:** a switch that is up at reset produces an `in_rise` once it is accepted. Downstream must tolerate this startup strobe.
- **Latency:** from a raw change to the `in_db` change, 2 cycles (synchroniser) plus `STABLE_CNT` ticks, with the last tick's edge included. The worst case is 2 + `STABLE_CNT*TICK_DIV` cycles.
- **Strobe width:** exactly one cycle. No strobe repeats while the input stays stable.
- **Reset mid-count:** `rst` has priority every cycle. Partial counts are discarded, `in_db` returns to 0 and no strobe is emitted during reset.
- **`STABLE_CNT` = 1:** the first disagreeing tick accepts.

## Configuration
- **Macro:** `BOARD_INPUT_EDGE_EN`.
- **Defined:** the edge logic (`in_rise`, `in_fall`, `in_changed`) is built as described above.
- **Undefined:** `in_rise`, `in_fall` and `in_changed` are tied to constant 0 and no strobe flops are built. `in_db` behaviour is unchanged.

## Test plan
Bench parameters: `CLK_FREQ`=1, `SAMPLE_US`=4 (ticks where `pre` = 3, i.e. cycles 3, 7, 11, … after reset release), `STABLE_CNT`=3, macro defined.
- **Single press:** `btn_u` held at 1 from cycle 0 after reset. Required: `sync2[9]` = 1 by cycle 2, accepts on the cycle-11 tick, `in_db` = 13'h0200 from cycle 12, and `in_rise` = 13'h0200 plus `in_changed` = 1 for cycle 12 only.
- **Glitch rejection:** `switch[0]` pulses high for 6 cycles (covers ≤ 2 ticks). Required: `in_db` stays 0 and no strobes occur.
- **Bounce:** `btn_s` toggles every 3 cycles for 20 cycles, then stays 1. Required: exactly one `in_rise[12]`, asserted after the 3rd consecutive high tick once stable, and no `in_fall`.
- **Simultaneous accepts:** `switch` = 8'hA5 applied at once. Required: `in_db` = 13'h00A5, `in_rise` = 13'h00A5 for one cycle, and a single `in_changed` pulse.
- **Release:** from `in_db` = 13'h0200, release `btn_u`. Required: `in_fall` = 13'h0200 for one cycle, after which `in_db` = 0.
- **Reset mid-count:** assert `rst` after 2 disagreeing ticks, release it, and keep the input high. Required: all outputs 0 during reset, and acceptance needs a full 3 new ticks after release.

Source files
------------

// File: rtl/board_input_debounce.sv
// Two-flop synchroniser plus per-bit stable-sample filter for the Nexys3 switches and buttons.
// Defining BOARD_INPUT_EDGE_EN builds the registered rise/fall/changed strobes; otherwise they are tied to 0.
module board_input_debounce #(
  parameter int CLK_FREQ   = 100,
  parameter int SAMPLE_US  = 1000,
  parameter int STABLE_CNT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  switch,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_s,
  output logic [12:0] in_db,
  output logic [12:0] in_rise,
  output logic [12:0] in_fall,
  output logic        in_changed
);

  localparam int N        = 13;
  localparam int TICK_DIV = CLK_FREQ * SAMPLE_US;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W    = (STABLE_CNT > 0) ? $clog2(STABLE_CNT + 1) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [N-1:0]     raw;
  logic [N-1:0]     sync1_p0;
  logic [N-1:0]     sync2_p1;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0]     accept;

  assign raw = {btn_s, btn_l, btn_r, btn_u, btn_d, switch};

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
    end else begin
      sync1_p0 <= raw;
      sync2_p1 <= sync1_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  assign tick = (pre == PRE_LAST);

  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = tick && (sync2_p1[i] != in_db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Stage p2: stable-sample filter; any agreeing sample restarts the run
  always_ff @(posedge clk) begin
    if (rst) begin
      in_db <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (sync2_p1[i] == in_db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          in_db[i] <= sync2_p1[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BOARD_INPUT_EDGE_EN
  // Stage p2: strobes land on the same edge as the level they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      in_rise    <= '0;
      in_fall    <= '0;
      in_changed <= 1'b0;
    end else begin
      in_rise    <= accept & sync2_p1;
      in_fall    <= accept & ~sync2_p1;
      in_changed <= |accept;
    end
  end
`else
  assign in_rise    = '0;
  assign in_fall    = '0;
  assign in_changed = 1'b0;
`endif

endmodule
